instruction_fetch_unit: RTL and testbench

//  Fetch stage upstream of the RV32I control unit: owns PC, issues instruction-memory reads,

---
 rtl/instruction_fetch_unit_pkg.sv | 21 ++
 rtl/instruction_fetch_unit_if.sv | 11 +
 rtl/instruction_fetch_unit_pc_next.sv | 16 +
 rtl/instruction_fetch_unit.sv | 103 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared RV32I definitions for the fetch stage: opcodes, NOP encoding, fetch FSM states.
package instruction_fetch_unit_pkg;
   localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
   localparam logic [31:0] NOP          = 32'h0000_0013;

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;

   typedef enum logic [1:0] {
      FETCH_REQ   = 2'd0,
      FETCH_WAIT  = 2'd1,
      FETCH_READY = 2'd2
   } fetch_state_e;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port: request/grant plus a separate read-data valid.
interface instruction_fetch_unit_if #(parameter int XLEN = 32);
   logic            req;
   logic [XLEN-1:0] addr;
   logic            gnt;
   logic            rvalid;
   logic [31:0]     rdata;

   modport master (output req, output addr, input gnt, input rvalid, input rdata);
   modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/instruction_fetch_unit_pc_next.sv
// Next-PC selection: sequential PC+4 or word-aligned branch target, with misalignment flag.
module pc_next_logic #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_pc_src,
   input  logic [XLEN-1:0] i_branch_target,
   output logic [XLEN-1:0] o_next_pc,
   output logic [XLEN-1:0] o_pc_plus4,
   output logic            o_misalign
);
   assign o_pc_plus4 = i_pc + XLEN'(4);
   // Low target bits are dropped rather than trapped; the sticky flag records it.
   assign o_next_pc  = i_pc_src ? {i_branch_target[XLEN-1:2], 2'b00} : o_pc_plus4;
   assign o_misalign = i_pc_src & (|i_branch_target[1:0]);
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, wait-state tolerant imem fetch FSM, IR and RV32I field slicing.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0040_0000)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_pc_write,
   input  logic                      i_pc_src,
   input  logic [XLEN-1:0]           i_branch_target,
   instruction_fetch_unit_if.master  imem,
   output logic [31:0]               o_instr,
   output logic [6:0]                o_opcode,
   output logic [2:0]                o_funct3,
   output logic [6:0]                o_funct7,
   output logic [4:0]                o_rs1,
   output logic [4:0]                o_rs2,
   output logic [4:0]                o_rd,
   output logic [XLEN-1:0]           o_pc,
   output logic [XLEN-1:0]           o_pc_plus4,
   output logic                      o_instr_valid,
   output logic                      o_misaligned
);
   fetch_state_e    r_state, w_state_nxt;
   logic [XLEN-1:0] r_pc, w_next_pc, w_pc_plus4;
   logic [31:0]     r_ir;
   logic            r_misaligned, w_misalign;
   logic            w_req, w_ir_load, w_pc_load, w_valid;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_state <= FETCH_REQ;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FETCH_REQ:   if (imem.gnt) w_state_nxt = imem.rvalid ? FETCH_READY : FETCH_WAIT;
         FETCH_WAIT:  if (imem.rvalid) w_state_nxt = FETCH_READY;
         FETCH_READY: if (i_pc_write) w_state_nxt = FETCH_REQ;
         default:     w_state_nxt = FETCH_REQ;
      endcase
   end

   always_comb begin
      w_req     = 1'b0;
      w_ir_load = 1'b0;
      w_pc_load = 1'b0;
      w_valid   = 1'b0;
      case (r_state)
         FETCH_REQ: begin
            w_req     = 1'b1;
            w_ir_load = imem.gnt & imem.rvalid;
         end
         FETCH_WAIT:  w_ir_load = imem.rvalid;
         FETCH_READY: begin
            w_valid   = 1'b1;
            w_pc_load = i_pc_write;
         end
         default: ;
      endcase
   end

   pc_next_logic #(.XLEN(XLEN)) u_pc_next (
      .i_pc            (r_pc),
      .i_pc_src        (i_pc_src),
      .i_branch_target (i_branch_target),
      .o_next_pc       (w_next_pc),
      .o_pc_plus4      (w_pc_plus4),
      .o_misalign      (w_misalign)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_pc         <= RESET_PC;
         r_ir         <= NOP;
         r_misaligned <= 1'b0;
      end else begin
         if (w_ir_load) r_ir <= imem.rdata;
         if (w_pc_load) begin
            r_pc <= w_next_pc;
            if (w_misalign) r_misaligned <= 1'b1;
         end
      end
   end

   // The state register resets to REQ, so gate the request while reset is held.
   assign imem.req      = w_req & i_rst;
   assign imem.addr     = r_pc;
   assign o_instr       = r_ir;
   assign o_opcode      = r_ir[6:0];
   assign o_rd          = r_ir[11:7];
   assign o_funct3      = r_ir[14:12];
   assign o_rs1         = r_ir[19:15];
   assign o_rs2         = r_ir[24:20];
   assign o_funct7      = r_ir[31:25];
   assign o_pc          = r_pc;
   assign o_pc_plus4    = w_pc_plus4;
   assign o_instr_valid = w_valid;
   assign o_misaligned  = r_misaligned;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: directed scenarios plus randomized memory/control traffic vs a transaction model.
module tb_instruction_fetch_unit;
   logic        clk;
   logic        rst;
   logic        pc_write, pc_src;
   logic [31:0] bt;
   logic [31:0] instr, pc, pc_plus4;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2, rd;
   logic        instr_valid, misaligned;

   int n_chk = 0;
   int n_fail = 0;

   instruction_fetch_unit_if bus ();

   instruction_fetch_unit dut (
      .i_clk(clk), .i_rst(rst), .i_pc_write(pc_write), .i_pc_src(pc_src),
      .i_branch_target(bt), .imem(bus),
      .o_instr(instr), .o_opcode(opcode), .o_funct3(funct3), .o_funct7(funct7),
      .o_rs1(rs1), .o_rs2(rs2), .o_rd(rd), .o_pc(pc), .o_pc_plus4(pc_plus4),
      .o_instr_valid(instr_valid), .o_misaligned(misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: a fetch is either not yet accepted, accepted and awaiting data, or delivered.
   logic [31:0] m_pc, m_ir;
   bit          m_have, m_accepted, m_mis;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0040_0000; m_ir = 32'h0000_0013;
      m_have = 0; m_accepted = 0; m_mis = 0;
   endtask

   task automatic model_edge();
      if (!m_have) begin
         if (m_accepted || bus.gnt) begin
            if (bus.rvalid) begin
               m_ir = bus.rdata; m_have = 1; m_accepted = 0;
            end else m_accepted = 1;
         end
      end else if (pc_write) begin
         m_have = 0;
         if (pc_src) begin
            m_pc = bt & 32'hFFFF_FFFC;
            if (bt % 4 != 0) m_mis = 1;
         end else m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic model_cmp();
      chk("req",      {31'd0, bus.req},     {31'd0, !m_have && !m_accepted});
      chk("addr",     bus.addr,             m_pc);
      chk("pc",       pc,                   m_pc);
      chk("pc_plus4", pc_plus4,             m_pc + 32'd4);
      chk("valid",    {31'd0, instr_valid}, {31'd0, m_have});
      chk("mis",      {31'd0, misaligned},  {31'd0, m_mis});
      chk("instr",    instr,                m_ir);
      chk("opcode",   {25'd0, opcode},      m_ir % 128);
      chk("rd",       {27'd0, rd},          (m_ir / 128) % 32);
      chk("funct3",   {29'd0, funct3},      (m_ir / 4096) % 8);
      chk("rs1",      {27'd0, rs1},         (m_ir / 32768) % 32);
      chk("rs2",      {27'd0, rs2},         (m_ir / 1048576) % 32);
      chk("funct7",   {25'd0, funct7},      m_ir / 33554432);
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic step();
      @(posedge clk);
      if (rst) model_edge();
      @(negedge clk);
      if (rst) model_cmp();
   endtask

   task automatic drive(input bit g, input bit v, input logic [31:0] d,
                        input bit pw, input bit ps, input logic [31:0] t);
      bus.gnt = g; bus.rvalid = v; bus.rdata = d;
      pc_write = pw; pc_src = ps; bt = t;
   endtask

   task automatic fetch(input logic [31:0] d);
      drive(1, 1, d, 0, 0, 0);
      step();
   endtask

   initial begin
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_req",   {31'd0, bus.req},     0);
      chk("rst_pc",    pc,                   32'h0040_0000);
      chk("rst_instr", instr,                32'h0000_0013);
      chk("rst_valid", {31'd0, instr_valid}, 0);
      chk("rst_mis",   {31'd0, misaligned},  0);

      // Zero-wait fetch right after reset release.
      rst = 1'b1;
      drive(1, 1, 32'h0050_0093, 0, 0, 0);
      #1;
      chk("t1_req",  {31'd0, bus.req}, 1);
      chk("t1_addr", bus.addr,         32'h0040_0000);
      step();
      chk("t1_valid",  {31'd0, instr_valid}, 1);
      chk("t1_opcode", {25'd0, opcode},      32'h13);
      chk("t1_rd",     {27'd0, rd},          1);
      chk("t1_funct3", {29'd0, funct3},      0);

      // Sequential commit.
      drive(0, 0, 0, 1, 0, 0);
      step();
      chk("t3_addr", bus.addr, 32'h0040_0004);

      // Wait states with pc_write pulses that must be ignored.
      drive(0, 1, 32'hDEAD_BEEF, 1, 1, 32'h1234_5670);
      step();
      chk("t2_req0", {31'd0, bus.req}, 1);
      drive(0, 0, 0, 0, 0, 0);
      step();
      chk("t2_req1", {31'd0, bus.req}, 1);
      drive(1, 0, 0, 0, 0, 0);
      step();
      chk("t2_req_wait", {31'd0, bus.req}, 0);
      drive(0, 0, 0, 1, 1, 32'h0000_1000);
      step();
      drive(0, 0, 0, 1, 0, 0);
      step();
      chk("t3_pc_hold", pc, 32'h0040_0004);
      chk("t2_novalid", {31'd0, instr_valid}, 0);
      drive(0, 1, 32'h0000_0033, 0, 0, 0);
      step();
      chk("t2_valid", {31'd0, instr_valid}, 1);
      chk("t2_instr", instr, 32'h0000_0033);

      // Aligned then misaligned branch.
      drive(0, 0, 0, 1, 1, 32'h0040_0100);
      step();
      chk("t4_addr", bus.addr, 32'h0040_0100);
      chk("t4_mis0", {31'd0, misaligned}, 0);
      fetch(32'h0000_0063);
      drive(0, 0, 0, 1, 1, 32'h0040_0102);
      step();
      chk("t4_addr_al", bus.addr, 32'h0040_0100);
      chk("t4_mis1", {31'd0, misaligned}, 1);
      fetch(32'h0000_006F);
      drive(0, 0, 0, 1, 0, 0);
      step();
      chk("t4_mis_sticky", {31'd0, misaligned}, 1);

      // Wrap-around from the top of the address space.
      fetch(32'h0000_0013);
      drive(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
      step();
      fetch(32'h0000_0013);
      chk("t5_plus4", pc_plus4, 32'h0000_0000);
      drive(0, 0, 0, 1, 0, 0);
      step();
      chk("t5_addr", bus.addr, 32'h0000_0000);

      // Asynchronous reset in the middle of a waited fetch.
      drive(1, 0, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0);
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk("t6_req",   {31'd0, bus.req},     0);
      chk("t6_pc",    pc,                   32'h0040_0000);
      chk("t6_instr", instr,                32'h0000_0013);
      chk("t6_valid", {31'd0, instr_valid}, 0);
      chk("t6_mis",   {31'd0, misaligned},  0);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 1, 32'hBAD0_0BAD, 0, 0, 0);
      step();
      chk("t6_stale_valid", {31'd0, instr_valid}, 0);
      chk("t6_req2", {31'd0, bus.req}, 1);
      chk("t6_addr", bus.addr, 32'h0040_0000);
      fetch(32'h0010_0113);
      chk("t6_instr2", instr, 32'h0010_0113);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] t;
         t = $urandom;
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom,
               $urandom_range(0, 2) == 0, $urandom_range(0, 1), t);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
